// File: rtl/data_cache.sv
// Direct-mapped, write-back/write-allocate data cache between a 16-bit CPU port
// and a line-wide memory port with fixed four-cycle line transfers.
module data_cache #(
    parameter int LINES = 4,
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                c_read,
    input  logic                c_write,
    input  logic [15:0]         c_address,
    input  logic [15:0]         c_wdata,
    output logic [15:0]         c_rdata,
    output logic                c_ready,
    output logic                d_readM,
    output logic                d_writeM,
    output logic [15:0]         d_address,
    inout  wire  [16*WORDS-1:0] d_data,
    output logic [15:0]         hit_count,
    output logic [15:0]         miss_count
);

    localparam int OFF_W  = $clog2(WORDS);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = 16 - OFF_W - IDX_W;
    localparam int LINE_W = 16 * WORDS;

    typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [LINES-1:0]   dirty_q, dirty_d;
    logic [15:0]        hit_q, hit_d;
    logic [15:0]        miss_q, miss_d;

    logic [LINE_W-1:0]  data_q [LINES];
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [IDX_W-1:0]   req_idx_q;
    logic [TAG_W-1:0]   req_tag_q;
    logic [OFF_W-1:0]   req_off_q;

    logic [IDX_W-1:0]   idx, lk_idx;
    logic [TAG_W-1:0]   tag;
    logic [OFF_W-1:0]   off, lk_off;
    logic               req_any, hit;
    logic [LINE_W-1:0]  line_rd, line_wr;
    logic [15:0]        rd_word;
    logic               wr_word_en, fill_en, req_latch;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign idx     = c_address[OFF_W +: IDX_W];
    assign tag     = c_address[15 -: TAG_W];
    assign off     = c_address[OFF_W-1:0];
    assign req_any = c_read | c_write;
    assign hit     = req_any && valid_q[idx] && (tag_q[idx] == tag);

    // Once a miss is in flight, the latched request selects the line, so an
    // illegally changed address cannot redirect the transfer or the completion.
    assign lk_idx  = (state_q == IDLE) ? idx : req_idx_q;
    assign lk_off  = (state_q == IDLE) ? off : req_off_q;
    assign line_rd = data_q[lk_idx];
    assign rd_word = line_rd[{lk_off, 4'b0000} +: 16];

    always_comb begin
        line_wr = line_rd;
        line_wr[{lk_off, 4'b0000} +: 16] = c_wdata;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        hit_d      = hit_q;
        miss_d     = miss_q;
        c_ready    = 1'b0;
        d_readM    = 1'b0;
        d_writeM   = 1'b0;
        d_address  = 16'h0000;
        wr_word_en = 1'b0;
        fill_en    = 1'b0;
        req_latch  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    if (hit) begin
                        c_ready    = 1'b1;
                        hit_d      = sat_inc(hit_q);
                        wr_word_en = c_write;
                    end else begin
                        req_latch = 1'b1;
                        cnt_d     = 2'd0;
                        miss_d    = sat_inc(miss_q);
                        state_d   = (valid_q[idx] && dirty_q[idx]) ? WB : FILL;
                    end
                end
            end
            WB: begin
                d_writeM  = 1'b1;
                d_address = {tag_q[req_idx_q], req_idx_q, {OFF_W{1'b0}}};
                cnt_d     = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    cnt_d   = 2'd0;
                    state_d = FILL;
                end
            end
            FILL: begin
                d_readM   = 1'b1;
                d_address = {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
                cnt_d     = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    cnt_d              = 2'd0;
                    fill_en            = 1'b1;
                    valid_d[req_idx_q] = 1'b1;
                    dirty_d[req_idx_q] = 1'b0;
                    state_d            = DONE;
                end
            end
            DONE: begin
                c_ready    = 1'b1;
                wr_word_en = c_write;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (wr_word_en) dirty_d[lk_idx] = 1'b1;
    end

    assign c_rdata    = c_ready ? rd_word : 16'h0000;
    assign d_data     = d_writeM ? data_q[req_idx_q] : {LINE_W{1'bz}};
    assign hit_count  = hit_q;
    assign miss_count = miss_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            valid_q <= '0;
            dirty_q <= '0;
            hit_q   <= 16'h0000;
            miss_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    // Line storage and the latched request carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (req_latch) begin
            req_idx_q <= idx;
            req_tag_q <= tag;
            req_off_q <= off;
        end
        if (fill_en) begin
            data_q[req_idx_q] <= d_data;
            tag_q[req_idx_q]  <= req_tag_q;
        end else if (wr_word_en) begin
            data_q[lk_idx] <= line_wr;
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: a line memory model, a scoreboard of expected
// CPU completions, and a monitor that pops and checks on every c_ready.
module tb_data_cache;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        c_read = 1'b0;
    logic        c_write = 1'b0;
    logic [15:0] c_address = 16'h0000;
    logic [15:0] c_wdata = 16'h0000;
    logic [15:0] c_rdata;
    logic        c_ready;
    logic        d_readM;
    logic        d_writeM;
    logic [15:0] d_address;
    wire  [63:0] d_data;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    data_cache #(.LINES(4), .WORDS(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .c_read(c_read), .c_write(c_write), .c_address(c_address), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_ready(c_ready),
        .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address), .d_data(d_data),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: drives the addressed line whenever a read is requested,
    // absorbs the write-back line on every write cycle.
    logic [15:0] mem [0:255];
    logic [63:0] mem_line;
    assign mem_line = {mem[{d_address[7:2], 2'd3}], mem[{d_address[7:2], 2'd2}],
                       mem[{d_address[7:2], 2'd1}], mem[{d_address[7:2], 2'd0}]};
    assign d_data = d_readM ? mem_line : 64'bz;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h23] = 16'h6000;
        mem[8'h61] = 16'hf4c6;
        mem[8'h62] = 16'hfc1c;
        mem[8'h63] = 16'hf8c6;
        forever begin
            @(posedge clk);
            if (d_writeM) begin
                for (int k = 0; k < 4; k++)
                    mem[{d_address[7:2], 2'(k)}] = d_data[16*k +: 16];
            end
        end
    end

    // Bus activity monitor
    int          rd_cyc = 0, wr_cyc = 0, overlap = 0, idle_viol = 0, wr_chg = 0;
    logic [15:0] rd_addr_last = 16'h0, wr_addr_last = 16'h0;
    logic [63:0] wr_data_last = 64'h0;
    logic        wr_prev = 1'b0;
    always @(negedge clk) begin
        if (d_readM && d_writeM) overlap++;
        if (d_readM) begin
            rd_cyc++;
            rd_addr_last = d_address;
        end
        if (d_writeM) begin
            wr_cyc++;
            if (wr_prev && d_data !== wr_data_last) wr_chg++;
            wr_addr_last = d_address;
            wr_data_last = d_data;
        end
        wr_prev = d_writeM;
        if (!d_readM && !d_writeM && d_address != 16'h0) idle_viol++;
        if (!c_ready && c_rdata != 16'h0) idle_viol++;
    end

    // Scoreboard
    typedef struct {
        logic [15:0] rdata;
        bit          chk;
        int          cyc;
        string       name;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        if (reset_n && c_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_latency"}, 64'(cyc), 64'(e.cyc));
                if (e.chk) check({e.name, "_rdata"}, 64'(c_rdata), 64'(e.rdata));
            end
        end
    end

    task automatic req(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [15:0] exp, input bit chk,
                       input int lat, input int exp_rd, input int exp_wr, input string nm);
        int  rd0, wr0;
        bit  got;
        exp_t e;
        @(posedge clk);
        #1;
        rd0 = rd_cyc;
        wr0 = wr_cyc;
        e.rdata = exp; e.chk = chk; e.cyc = cyc + lat; e.name = nm;
        sb.push_back(e);
        c_read = rd; c_write = wr; c_address = addr; c_wdata = wdata;
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (c_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check({nm, "_timeout"}, 64'd0, 64'd1);
            sb.delete();
        end
        @(posedge clk);
        #1;
        c_read = 1'b0; c_write = 1'b0;
        check({nm, "_rd_cycles"}, 64'(rd_cyc - rd0), 64'(exp_rd));
        check({nm, "_wr_cycles"}, 64'(wr_cyc - wr0), 64'(exp_wr));
    endtask

    initial begin
        #12;
        check("rst_c_ready", 64'(c_ready), 64'd0);
        check("rst_d_readM", 64'(d_readM), 64'd0);
        check("rst_d_writeM", 64'(d_writeM), 64'd0);
        check("rst_hit_count", 64'(hit_count), 64'd0);
        check("rst_miss_count", 64'(miss_count), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        req(1'b1, 1'b0, 16'h0023, 16'h0, 16'h6000, 1'b1, 5, 4, 0, "cold_load");
        check("cold_rd_addr", 64'(rd_addr_last), 64'h0020);
        check("cold_miss_count", 64'(miss_count), 64'd1);
        check("cold_hit_count", 64'(hit_count), 64'd0);

        req(1'b1, 1'b0, 16'h0021, 16'h0, 16'h0000, 1'b1, 0, 0, 0, "hit_load");
        check("hit_hit_count", 64'(hit_count), 64'd1);

        req(1'b0, 1'b1, 16'h0022, 16'hBEEF, 16'h0, 1'b0, 0, 0, 0, "hit_store");
        req(1'b1, 1'b0, 16'h0022, 16'h0, 16'hBEEF, 1'b1, 0, 0, 0, "load_back");
        check("store_hit_count", 64'(hit_count), 64'd3);

        req(1'b1, 1'b0, 16'h0062, 16'h0, 16'hfc1c, 1'b1, 9, 4, 4, "dirty_load");
        check("dirty_wr_addr", 64'(wr_addr_last), 64'h0020);
        check("dirty_wr_data", wr_data_last, 64'h6000_BEEF_0000_0000);
        check("dirty_wr_stable", 64'(wr_chg), 64'd0);
        check("dirty_rd_addr", 64'(rd_addr_last), 64'h0060);
        check("dirty_miss_count", 64'(miss_count), 64'd2);
        check("dirty_hit_count", 64'(hit_count), 64'd3);

        // Clean miss on index 0, aborted by reset in its second FILL cycle
        @(posedge clk);
        #1;
        c_read = 1'b1; c_address = 16'h0020;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("abort_fill_active", 64'(d_readM), 64'd1);
        check("abort_miss_count", 64'(miss_count), 64'd3);
        reset_n = 1'b0;
        #1;
        check("abort_d_readM", 64'(d_readM), 64'd0);
        check("abort_d_writeM", 64'(d_writeM), 64'd0);
        check("abort_c_ready", 64'(c_ready), 64'd0);
        check("abort_hit_count", 64'(hit_count), 64'd0);
        check("abort_miss_count_clr", 64'(miss_count), 64'd0);
        c_read = 1'b0; c_address = 16'h0000;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        req(1'b1, 1'b0, 16'h0062, 16'h0, 16'hfc1c, 1'b1, 5, 4, 0, "post_rst_load");
        check("post_rst_miss_count", 64'(miss_count), 64'd1);
        check("post_rst_hit_count", 64'(hit_count), 64'd0);

        req(1'b1, 1'b1, 16'h0063, 16'h1234, 16'h0, 1'b0, 0, 0, 0, "rw_store");
        check("rw_hit_count", 64'(hit_count), 64'd1);
        check("rw_mem_untouched", 64'(mem[8'h63]), 64'hf8c6);

        req(1'b1, 1'b0, 16'h0022, 16'h0, 16'hBEEF, 1'b1, 9, 4, 4, "evict_load");
        check("evict_wr_addr", 64'(wr_addr_last), 64'h0060);
        check("evict_wr_data", wr_data_last, 64'h1234_fc1c_f4c6_0000);
        check("evict_mem_63", 64'(mem[8'h63]), 64'h1234);
        check("evict_miss_count", 64'(miss_count), 64'd2);

        req(1'b1, 1'b0, 16'h0063, 16'h0, 16'h1234, 1'b1, 5, 4, 0, "refetch_load");
        check("refetch_miss_count", 64'(miss_count), 64'd3);
        check("refetch_hit_count", 64'(hit_count), 64'd1);

        repeat (2) @(posedge clk);
        #1;
        check("idle_d_address", 64'(d_address), 64'h0);
        check("bus_overlap", 64'(overlap), 64'd0);
        check("idle_outputs", 64'(idle_viol), 64'd0);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter LINES, default 4, number of direct-mapped lines (power of two).
REQ-002 Parameter WORDS, default 4, 16-bit words per line; the line is 64 bits wide.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 c_read  input  1  CPU load request; held until c_ready.
REQ-006 c_write  input  1  CPU store request; held until c_ready.
REQ-007 c_address  input  16  CPU word address, held stable until c_ready.
REQ-008 c_wdata  input  16  store data, held stable until c_ready.
REQ-009 c_rdata  output  16  load data, valid while c_ready=1.
REQ-010 c_ready  output  1  request completes in this cycle.
REQ-011 d_readM  output  1  memory line-read request.
REQ-012 d_writeM  output  1  memory line-write request.
REQ-013 d_address  output  16  line-aligned memory address, so bits[1:0]=0.
REQ-014 d_data  inout  64  line data; driven only while d_writeM=1, else high-Z; word k is at bits [16k+15:16k].
REQ-015 hit_count, miss_count  output  16 each  saturating statistics counters.

Function
REQ-016 The address split SHALL be: offset=c_address[1:0], index=c_address[3:2], tag=c_address[15:4].
REQ-017 Each line SHALL hold valid, dirty, a 12-bit tag and 64 bits of data.
REQ-018 Stores SHALL use write-back with write-allocate.
REQ-019 If c_read and c_write are both high, the request SHALL be treated as a store.
REQ-020 The FSM SHALL have the states IDLE, WB, FILL and DONE.
REQ-021 IDLE, hit (valid and tag match): c_ready=1 combinationally in the same cycle.
- Load hit: c_rdata=line word[offset].
- Store hit: the word is updated and dirty set at the clock edge.
REQ-022 IDLE, miss with victim valid and dirty: go to WB.
REQ-023 IDLE, miss with victim clean or invalid: go to FILL.
REQ-024 WB: d_writeM=1 for exactly 4 cycles.
- d_address={victim tag, index, 2'b00}.
- d_data=victim line, held constant throughout.
- A 2-bit counter, cleared on entry, exits to FILL on the edge where it equals 3.
REQ-025 FILL: d_readM=1 for exactly 4 cycles, d_address={tag, index, 2'b00}.
- On the 4th edge, capture d_data into the line.
- On that edge: valid=1, dirty=0, tag written; go to DONE.
REQ-026 The cache SHALL deassert d_readM/d_writeM on the 4th edge; memory returns to its idle state there and must not see a re-request.
REQ-027 DONE: the request completes as a hit (REQ-021) on the next cycle, then returns to IDLE.
- Total load-miss latency: 9 cycles dirty, 5 cycles clean.
REQ-028 d_readM and d_writeM SHALL never both be 1.
REQ-029 Outside WB/FILL: d_readM=0, d_writeM=0, d_address=0.
REQ-030 c_rdata=0 whenever c_ready=0.
REQ-031 miss_count SHALL increment by 1 on each IDLE->WB or IDLE->FILL transition.
REQ-032 hit_count SHALL increment on a c_ready cycle only if the request took no miss.
REQ-033 Both counters SHALL saturate at 16'hFFFF.
REQ-034 Request inputs changing before c_ready is illegal; behaviour is undefined but the FSM SHALL still finish the memory transaction in progress.

Reset
REQ-035 On reset_n=0, effective immediately regardless of state (including mid-WB or mid-FILL):
- state=IDLE and counter=0.
- All valid and dirty bits cleared.
- d_readM=0, d_writeM=0, d_data high-Z, c_ready=0.
- hit_count=0 and miss_count=0.
REQ-036 Line data and tags are not required to be reset.

Verification (memory model: 4-cycle read/write timing; [0x20..0x23]=0000,0000,0000,6000; [0x60..0x63]=0000,f4c6,fc1c,f8c6)
REQ-037 Cold load 0x0023:
- d_readM high for 4 cycles at d_address=0x0020.
- c_ready 5 cycles after the request with c_rdata=0x6000.
- miss_count=1.
REQ-038 Then load 0x0021: c_ready in the same cycle, c_rdata=0x0000, hit_count=1, no memory activity.
REQ-039 Store 0x0022=0xBEEF: hit with c_ready in the same cycle; then load 0x0022 returns 0xBEEF.
REQ-040 Then load 0x0062 (same index, dirty victim):
- d_writeM for 4 cycles at 0x0020 with d_data=0x6000_BEEF_0000_0000.
- Then d_readM for 4 cycles at 0x0060.
- c_rdata=0xfc1c at cycle 9; miss_count=2.
REQ-041 Assert reset_n=0 during the 2nd FILL cycle:
- d_readM drops immediately.
- After release, load 0x0062 misses again (valid cleared) and both counters restart from 0.
REQ-042 Load with c_read=c_write=1: handled as a store, memory line updated on a later eviction, d_readM/d_writeM never overlap.
